// File: rtl/pri_enc16x4_hs.sv
// 16-to-4 priority encoder with sticky request capture and a valid/ready output stage.
// Each issued index leaves the pending vector. A re-request of a bit already pending raises a one-cycle merged pulse.
module pri_enc16x4_hs #(
  parameter bit HIGH_WINS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  code,
  output logic [15:0] pending,
  output logic        merged
);

  logic [15:0] pending_r;
  logic [3:0]  code_r;
  logic        valid_r;
  logic        merged_r;

  logic [3:0]  grp_any_s;
  logic [1:0]  grp_s;
  logic [3:0]  nib_s;
  logic [1:0]  low_s;
  logic [3:0]  sel_s;
  logic [15:0] sel_mask_s;
  logic [15:0] clr_mask_s;
  logic [15:0] pending_nxt_s;
  logic        merged_nxt_s;
  logic        load_s;

  // 4-way priority pick. Direction follows HIGH_WINS; used for both group and in-nibble levels.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (HIGH_WINS) begin
      if (v[3])      r = 2'd3;
      else if (v[2]) r = 2'd2;
      else if (v[1]) r = 2'd1;
      else           r = 2'd0;
    end else begin
      if (v[0])      r = 2'd0;
      else if (v[1]) r = 2'd1;
      else if (v[2]) r = 2'd2;
      else if (v[3]) r = 2'd3;
      else           r = 2'd0;
    end
    return r;
  endfunction

  // Group-level select over the OR of each nibble of pending
  always_comb begin
    grp_any_s[0] = |pending_r[3:0];
    grp_any_s[1] = |pending_r[7:4];
    grp_any_s[2] = |pending_r[11:8];
    grp_any_s[3] = |pending_r[15:12];
    grp_s        = enc4(grp_any_s);
  end

  // Index within the chosen nibble, then the full select and its one-hot mask
  always_comb begin
    case (grp_s)
      2'd0:    nib_s = pending_r[3:0];
      2'd1:    nib_s = pending_r[7:4];
      2'd2:    nib_s = pending_r[11:8];
      2'd3:    nib_s = pending_r[15:12];
      default: nib_s = pending_r[3:0];
    endcase
    low_s = enc4(nib_s);
    sel_s = {grp_s, low_s};
    if (pending_r != 16'h0000) begin
      sel_mask_s = 16'h0001 << sel_s;
    end else begin
      sel_mask_s = 16'h0000;
    end
  end

  assign load_s = (!valid_r || ready) && (pending_r != 16'h0000);

  // Next pending: the loaded bit moves out, new requests set bits; set wins over clear
  always_comb begin
    if (load_s) begin
      clr_mask_s = sel_mask_s;
    end else begin
      clr_mask_s = 16'h0000;
    end
    pending_nxt_s = (pending_r & ~clr_mask_s) | i;
    merged_nxt_s  = |(i & pending_r & ~clr_mask_s);
  end

  // State registers: reset, then flush, then normal capture/issue
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 16'h0000;
      code_r    <= 4'h0;
      valid_r   <= 1'b0;
      merged_r  <= 1'b0;
    end else if (flush) begin
      pending_r <= 16'h0000;
      code_r    <= 4'h0;
      valid_r   <= 1'b0;
      merged_r  <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      merged_r  <= merged_nxt_s;
      if (load_s) begin
        code_r  <= sel_s;
        valid_r <= 1'b1;
      end else if (ready) begin
        code_r  <= code_r;
        valid_r <= 1'b0;
      end else begin
        code_r  <= code_r;
        valid_r <= valid_r;
      end
    end
  end

  assign valid   = valid_r;
  assign code    = code_r;
  assign pending = pending_r;
  assign merged  = merged_r;

endmodule
